// File: rtl/key_debounce.sv
// key_debounce: qualifies the bouncy press_raw/code_raw pair from the keypad
// decoder into one clean key_valid strobe per keystroke, with hold-to-repeat
// strobes while the key stays down and a key_release strobe on release.
module key_debounce #(
  parameter int unsigned DB_HITS        = 4,
  parameter int unsigned RELEASE_CYCLES = 8,
  parameter int unsigned RPT_DELAY      = 256,
  parameter int unsigned RPT_PERIOD     = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       press_raw,
  input  logic [3:0] code_raw,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic       key_release
);

  localparam int unsigned HIT_W   = $clog2(DB_HITS + 1);
  localparam int unsigned MISS_W  = $clog2(RELEASE_CYCLES + 1);
  // A zero repeat delay disables repeat; keep the counter one bit wide then.
  localparam int unsigned HOLD_W  = (RPT_DELAY > 0) ? $clog2(RPT_DELAY + 1) : 1;
  localparam int unsigned PHASE_W = (RPT_PERIOD > 1) ? $clog2(RPT_PERIOD) : 1;

  localparam logic [HIT_W-1:0]   HIT_MAX    = HIT_W'(DB_HITS);
  localparam logic [MISS_W-1:0]  MISS_MAX   = MISS_W'(RELEASE_CYCLES);
  localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(RPT_DELAY);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(RPT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_QUAL,
    S_HELD
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cand_q, cand_d;
  logic [HIT_W-1:0]    hit_q, hit_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [3:0]          code_q, code_d;
  logic                valid_q, valid_d;
  logic                release_q, release_d;
  logic                accept;
  logic                repeat_hit;

  // Next-state logic: qualification, hold/release tracking and repeat timing.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    cand_d     = cand_q;
    hit_d      = hit_q;
    miss_d     = miss_q;
    hold_d     = hold_q;
    phase_d    = phase_q;
    code_d     = code_q;
    valid_d    = 1'b0;
    release_d  = 1'b0;
    accept     = 1'b0;
    repeat_hit = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (press_raw) begin
          cand_d  = code_raw;
          hit_d   = HIT_W'(1);
          miss_d  = '0;
          state_d = S_QUAL;
          accept  = (hit_d == HIT_MAX);
        end
      end

      S_QUAL: begin
        if (press_raw) begin
          if (code_raw == cand_q) begin
            hit_d = hit_q + 1'b1;
          end else begin
            cand_d = code_raw;
            hit_d  = HIT_W'(1);
          end
          miss_d = '0;
          accept = (hit_d == HIT_MAX);
        end else begin
          // Miss reaches RELEASE_CYCLES and stays there until the next press.
          miss_d = miss_q + 1'b1;
          if (miss_d == MISS_MAX) begin
            state_d = S_IDLE;
          end
        end
      end

      S_HELD: begin
        // Repeat timing: hold counts up to the first repeat, then the phase
        // counter wraps every RPT_PERIOD cycles for the later ones.
        if (RPT_DELAY != 0) begin
          if (hold_q != HOLD_MAX) begin
            hold_d     = hold_q + 1'b1;
            repeat_hit = (hold_d == HOLD_MAX);
          end else begin
            phase_d    = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
            repeat_hit = (phase_q == PHASE_LAST);
          end
        end

        // A different code while held is treated exactly like no press.
        if (press_raw && (code_raw == code_q)) begin
          miss_d = '0;
        end else begin
          miss_d = miss_q + 1'b1;
        end

        // Release wins over a repeat landing on the same edge.
        if (miss_d == MISS_MAX) begin
          state_d   = S_IDLE;
          release_d = 1'b1;
        end else begin
          valid_d = repeat_hit;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      state_d = S_HELD;
      code_d  = cand_d;
      valid_d = 1'b1;
      hold_d  = '0;
      phase_d = '0;
      miss_d  = '0;
    end
  end

  // State and output registers; reset clears everything including the code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cand_q    <= '0;
      hit_q     <= '0;
      miss_q    <= '0;
      hold_q    <= '0;
      phase_q   <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      cand_q    <= cand_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      hold_q    <= hold_d;
      phase_q   <= phase_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      release_q <= release_d;
    end
  end

  assign key_valid   = valid_q;
  assign key_code    = code_q;
  assign key_held    = (state_q == S_HELD);
  assign key_release = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: a directed vector table, hand-written
// keystroke scenarios and a randomized run against a behavioural model.
module tb_key_debounce;

  localparam int DBH = 4;
  localparam int REL = 8;
  localparam int RD  = 32;
  localparam int RP  = 8;

  logic       clk;
  logic       rst;
  logic       press_raw;
  logic [3:0] code_raw;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic       key_release;

  key_debounce #(
    .DB_HITS       (DBH),
    .RELEASE_CYCLES(REL),
    .RPT_DELAY     (RD),
    .RPT_PERIOD    (RP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .press_raw  (press_raw),
    .code_raw   (code_raw),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_held   (key_held),
    .key_release(key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: mode 0 = waiting, 1 = counting hits, 2 = key down.
  // Repeat instants come from the age of the keystroke with plain arithmetic.
  int         m_mode, m_hits, m_miss, m_age;
  logic [3:0] m_cand, m_code;
  bit         e_valid, e_rel;

  task automatic model_reset();
    m_mode = 0; m_hits = 0; m_miss = 0; m_age = 0;
    m_cand = 4'h0; m_code = 4'h0; e_valid = 0; e_rel = 0;
  endtask

  task automatic model_step(input bit p, input logic [3:0] c);
    bit acc;
    acc = 0; e_valid = 0; e_rel = 0;
    case (m_mode)
      0: if (p) begin
        m_cand = c; m_hits = 1; m_miss = 0; m_mode = 1;
        acc = (m_hits == DBH);
      end
      1: if (p) begin
        if (c == m_cand) m_hits++;
        else begin m_cand = c; m_hits = 1; end
        m_miss = 0;
        acc = (m_hits == DBH);
      end else begin
        m_miss++;
        if (m_miss == REL) m_mode = 0;
      end
      default: begin
        m_age++;
        if (p && c == m_code) m_miss = 0;
        else m_miss++;
        if (m_miss == REL) begin
          m_mode = 0; e_rel = 1;
        end else if (RD != 0 && m_age >= RD && ((m_age - RD) % RP) == 0) begin
          e_valid = 1;
        end
      end
    endcase
    if (acc) begin
      m_mode = 2; m_code = m_cand; e_valid = 1; m_age = 0; m_miss = 0;
    end
  endtask

  // Event log for the directed scenarios: cycle numbers since the last reset.
  int cyc;
  int vq[$];
  int rq[$];

  // Apply one input sample, clock it, then compare all outputs with the model.
  task automatic drive(input bit p, input logic [3:0] c);
    press_raw = p;
    code_raw  = c;
    @(posedge clk);
    #1;
    model_step(p, c);
    check("key_valid", key_valid, e_valid);
    check("key_code", key_code, m_code);
    check("key_held", key_held, (m_mode == 2));
    check("key_release", key_release, e_rel);
    check("valid_release_excl", key_valid & key_release, 0);
    cyc++;
    if (key_valid) vq.push_back(cyc);
    if (key_release) rq.push_back(cyc);
  endtask

  task automatic run(input bit p, input logic [3:0] c, input int n);
    for (int i = 0; i < n; i++) drive(p, c);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_held", key_held, 0);
    check("rst_release", key_release, 0);
    #2;
    rst = 1'b0;
    cyc = 0;
    vq.delete();
    rq.delete();
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  typedef struct {
    bit         p;
    logic [3:0] c;
    bit         v;
    logic [3:0] k;
    bit         h;
    bit         r;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int held_drop;
    int prob;
    logic [3:0] cbase;

    // Glitch abort (3 hits, 8 misses) followed by a fresh 4-hit accept.
    for (int i = 0; i < 3; i++)   tbl[i] = '{1'b1, 4'h5, 1'b0, 4'h0, 1'b0, 1'b0};
    for (int i = 3; i < 11; i++)  tbl[i] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
    for (int i = 11; i < 14; i++) tbl[i] = '{1'b1, 4'h5, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 4'h5, 1'b1, 4'h5, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 4'h5, 1'b0, 4'h5, 1'b1, 1'b0};

    rst = 1'b1;
    press_raw = 1'b0;
    code_raw = 4'h0;
    model_reset();
    cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    check("init_valid", key_valid, 0);
    check("init_code", key_code, 0);
    check("init_held", key_held, 0);
    check("init_release", key_release, 0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].p, tbl[i].c);
      check("tbl_valid", key_valid, tbl[i].v);
      check("tbl_code", key_code, tbl[i].k);
      check("tbl_held", key_held, tbl[i].h);
      check("tbl_release", key_release, tbl[i].r);
    end

    // Clean press of 7 for 40 cycles, then released.
    do_reset();
    run(1'b1, 4'h7, 40);
    run(1'b0, 4'h0, 12);
    check("clean_valid_count", vq.size(), 3);
    check("clean_accept_at", qget(vq, 0), 4);
    check("clean_rpt1_at", qget(vq, 1), 36);
    check("clean_rpt2_at", qget(vq, 2), 44);
    check("clean_release_count", rq.size(), 1);
    check("clean_release_at", qget(rq, 0), 48);
    check("clean_code_kept", key_code, 4'h7);

    // Bounce: 2 high, 3 low, 2 high, then released.
    do_reset();
    run(1'b1, 4'h3, 2);
    run(1'b0, 4'h3, 3);
    run(1'b1, 4'h3, 2);
    run(1'b0, 4'h3, 10);
    check("bounce_valid_count", vq.size(), 1);
    check("bounce_accept_at", qget(vq, 0), 7);
    check("bounce_release_at", qget(rq, 0), 15);
    check("bounce_code", key_code, 4'h3);

    // Scan interleave: one hit in every four cycles.
    do_reset();
    held_drop = 0;
    for (int i = 0; i < 64; i++) begin
      drive((i % 4) == 0, 4'hA);
      if (cyc >= 13 && !key_held) held_drop++;
    end
    check("scan_accept_at", qget(vq, 0), 13);
    check("scan_valid_count", vq.size(), 4);
    check("scan_held_drops", held_drop, 0);
    check("scan_release_count", rq.size(), 0);

    // Code change while qualifying, then a second key while held.
    do_reset();
    run(1'b1, 4'h1, 2);
    run(1'b1, 4'h2, 4);
    run(1'b1, 4'h9, 8);
    run(1'b0, 4'h0, 2);
    check("chg_valid_count", vq.size(), 1);
    check("chg_accept_at", qget(vq, 0), 6);
    check("chg_release_count", rq.size(), 1);
    check("chg_release_at", qget(rq, 0), 14);
    check("chg_code", key_code, 4'h2);

    // Reset in the middle of a repeat strobe, then re-qualify.
    do_reset();
    run(1'b1, 4'h7, 36);
    check("mid_rpt_strobe", key_valid, 1);
    do_reset();
    run(1'b1, 4'h7, 6);
    check("requal_valid_count", vq.size(), 1);
    check("requal_accept_at", qget(vq, 0), 4);

    // Randomized segments with varying press density and a small code set.
    do_reset();
    for (int seg = 0; seg < 40; seg++) begin
      case ($urandom_range(0, 3))
        0:       prob = 10;
        1:       prob = 50;
        2:       prob = 85;
        default: prob = 100;
      endcase
      cbase = 4'($urandom_range(0, 12));
      for (int i = 0; i < 50; i++) begin
        drive($urandom_range(0, 99) < prob, cbase + 4'($urandom_range(0, 1)));
      end
      if (seg % 10 == 9) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
